ctrl_reg_file: RTL

//  Parametrised Zorro II control register file for the CIDER board; successor to the single-nibble control register.

---
 rtl/ctrl_reg_file_pkg.sv | 20 ++
 rtl/ctrl_ack_fsm.sv | 53 +++++
 rtl/ctrl_reg_file.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ctrl_reg_file_pkg.sv
// Shared encodings for the CIDER Zorro II control register file: Z2 bus states,
// register map indices and the DTACK handshake states.
package ctrl_reg_file_pkg;

    localparam logic [1:0] Z2_IDLE  = 2'd0;
    localparam logic [1:0] Z2_ADDR  = 2'd1;
    localparam logic [1:0] Z2_DATA  = 2'd2;
    localparam logic [1:0] Z2_END   = 2'd3;

    localparam int REG_CTRL     = 0;
    localparam int REG_PROGBANK = 1;
    localparam int REG_STATUS   = 2;
    localparam int REG_SCRATCH0 = 3;

    typedef enum logic {
        CTRL_IDLE = 1'b0,
        CTRL_ACK  = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/ctrl_ack_fsm.sv
// Qualifies a Z2 data-phase access to the control block and produces a one-edge
// access strobe plus DTACK held for the rest of the bus cycle.
module ctrl_ack_fsm
    import ctrl_reg_file_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_as_n,
    input  logic [1:0] i_z2_state,
    input  logic       i_ctrl_access,
    output logic       o_access_strobe,
    output logic       o_dtack
);

    ctrl_state_e r_state;
    ctrl_state_e w_next_state;
    logic        w_qualified;

    assign w_qualified = (i_z2_state == Z2_DATA) && i_ctrl_access && !i_as_n;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CTRL_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        w_next_state    = r_state;
        o_access_strobe = 1'b0;
        case (r_state)
            CTRL_IDLE: begin
                if (w_qualified) begin
                    w_next_state    = CTRL_ACK;
                    o_access_strobe = 1'b1;
                end
            end
            CTRL_ACK: begin
                // Stay here until the bus cycle ends so a long AS_n gives only one access.
                if (i_as_n || (i_z2_state != Z2_DATA)) begin
                    w_next_state = CTRL_IDLE;
                end
            end
            default: w_next_state = CTRL_IDLE;
        endcase
    end

    assign o_dtack = (r_state == CTRL_ACK);

endmodule

// File: rtl/ctrl_reg_file.sv
// CIDER Zorro II control register file: boot overlay, flash programming bank,
// other-RAM enable, read-only status and scratch nibbles with own DTACK.
module ctrl_reg_file
    import ctrl_reg_file_pkg::*;
#(
    parameter int         NUM_REGS = 4,
    parameter int         BANK_W   = 2,
    parameter logic [7:0] CIA_PAGE = 8'hBF
) (
    input  logic                        CLK,
    input  logic                        RESET_n,
    input  logic                        AS_n,
    input  logic                        RW,
    input  logic [7:0]                  ADDR,
    input  logic [$clog2(NUM_REGS)-1:0] reg_sel,
    input  logic [3:0]                  DIN,
    input  logic [1:0]                  z2_state,
    input  logic                        ctrl_access,
    input  logic                        flash_enabled,
    input  logic [BANK_W-1:0]           flash_bank,
    output logic [3:0]                  DOUT,
    output logic                        dtack,
    output logic                        flash_a18,
    output logic [BANK_W-1:0]           flash_bank_hi,
    output logic                        otherram_en,
    output logic                        OVL
);

    localparam int SEL_W = $clog2(NUM_REGS);

    logic              w_access_strobe;
    logic              w_wr;
    logic              w_rd;
    int                w_sel;
    logic              w_ctrl_wr;
    logic              w_cia_clear;
    logic [3:0]        w_rdata;

    logic              r_ovl;
    logic              r_otherram_en;
    logic [BANK_W-1:0] r_progbank;
    logic [3:0]        r_dout;
    logic [3:0]        r_scratch [REG_SCRATCH0:NUM_REGS-1];

    ctrl_ack_fsm u_ack_fsm (
        .clk             (CLK),
        .rst_n           (RESET_n),
        .i_as_n          (AS_n),
        .i_z2_state      (z2_state),
        .i_ctrl_access   (ctrl_access),
        .o_access_strobe (w_access_strobe),
        .o_dtack         (dtack)
    );

    assign w_sel       = {{(32-SEL_W){1'b0}}, reg_sel};
    assign w_wr        = w_access_strobe && !RW;
    assign w_rd        = w_access_strobe && RW;
    assign w_ctrl_wr   = w_wr && (w_sel == REG_CTRL);
    // The first write into CIA space means Kickstart is running; it drops the overlay whatever the decoder says.
    assign w_cia_clear = (ADDR == CIA_PAGE) && !RW && !AS_n;

    // DIN[0..2] carry bus bits 12..14: bit12 is the set/clear value, 13/14 select the targets.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_ovl         <= 1'b1;
            r_otherram_en <= 1'b0;
        end else begin
            if (w_ctrl_wr && DIN[1]) begin
                r_otherram_en <= DIN[0];
            end
            if (w_cia_clear) begin
                r_ovl <= 1'b0;
            end else if (w_ctrl_wr && DIN[2]) begin
                r_ovl <= DIN[0];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_progbank <= '0;
            r_dout     <= '0;
        end else begin
            if (w_wr && (w_sel == REG_PROGBANK)) begin
                r_progbank <= BANK_W'(DIN);
            end
            if (w_rd) begin
                r_dout <= w_rdata;
            end
        end
    end

    // NOTE: the scratch array is a handful of flops, so it is cleared on reset like any other register.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int i = REG_SCRATCH0; i < NUM_REGS; i++) begin
                r_scratch[i] <= 4'h0;
            end
        end else begin
            for (int i = REG_SCRATCH0; i < NUM_REGS; i++) begin
                if (w_wr && (w_sel == i)) begin
                    r_scratch[i] <= DIN;
                end
            end
        end
    end

    always_comb begin
        w_rdata = 4'h0;
        if (w_sel == REG_CTRL) begin
            w_rdata = {1'b0, r_ovl, r_otherram_en, 1'b0};
        end else if (w_sel == REG_PROGBANK) begin
            w_rdata = 4'(r_progbank);
        end else if (w_sel == REG_STATUS) begin
            w_rdata = {flash_enabled, 3'(flash_bank)};
        end else begin
            for (int i = REG_SCRATCH0; i < NUM_REGS; i++) begin
                if (w_sel == i) begin
                    w_rdata = r_scratch[i];
                end
            end
        end
    end

    assign DOUT          = r_dout;
    assign OVL           = r_ovl;
    assign otherram_en   = r_otherram_en;
    // While overlaid, the low half of the map fetches from the ROM image in the upper flash half.
    assign flash_a18     = (r_ovl && !ADDR[7]) ? 1'b1 : ADDR[3];
    assign flash_bank_hi = flash_enabled ? flash_bank : r_progbank;

endmodule
